ps2_host_tx: RTL and testbench

- PS/2 host-to-device transmitter. Sends command bytes to the mouse, e.g. 0xF4 "enable data reporting" and 0xFF "reset".
- Complements the receive-only mouse controller. Runs in the 100 MHz domain alongside it.
- Drives the shared PS2Clk/PS2Data lines through open-drain enables. Top level converts enables to tristate (oe=1 means drive 0, oe=0 means release).
- Asserts busy so the receiver ignores line activity during host transmission.

---
 rtl/ps2_pkg.sv | 26 ++
 rtl/ps2_host_tx_if.sv | 30 +++
 rtl/ps2_line_filter.sv | 54 +++++
 rtl/ps2_host_tx.sv | 198 +++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 325 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host transmitter states, command bytes
// and the microsecond-to-cycle conversion.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_START,
    ST_SHIFT,
    ST_ACK,
    ST_WAIT_IDLE
  } ps2_tx_state_e;

  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] CMD_SET_RATE = 8'hF3;
  localparam logic [7:0] ACK_BYTE     = 8'hFA;

  function automatic int unsigned us_to_cyc(
    input int unsigned clk_hz,
    input int unsigned us
  );
    return (clk_hz / 1_000_000) * us;
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command handshake between the mouse controller and the
// PS/2 host transmitter.
interface ps2_host_tx_if;

  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_done;
  logic       tx_err;
  logic       busy;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready,
    input  tx_done,
    input  tx_err,
    input  busy
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready,
    output tx_done,
    output tx_err,
    output busy
  );

endinterface

// File: rtl/ps2_line_filter.sv
// PS/2 pad conditioning: 2-FF synchronizers, clock debounce
// and a one-cycle falling-edge event on the filtered clock.
module ps2_line_filter #(
  parameter int unsigned FILTER_LEN = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clk_in,
  input  logic data_in,
  output logic clk_filt,
  output logic data_sync,
  output logic fall_evt
);

  localparam int unsigned FW = $clog2(FILTER_LEN + 1);

  logic [1:0]    clk_meta;
  logic [1:0]    data_meta;
  logic [FW-1:0] run_len;

  assign data_sync = data_meta[1];

  // Bring both pads into the clk domain; idle lines read high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_meta  <= 2'b11;
      data_meta <= 2'b11;
    end else begin
      clk_meta  <= {clk_meta[0], clk_in};
      data_meta <= {data_meta[0], data_in};
    end
  end

  // Flip the filtered clock only after a full run of new samples.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_filt <= 1'b1;
      run_len  <= '0;
      fall_evt <= 1'b0;
    end else begin
      fall_evt <= 1'b0;
      if (clk_meta[1] == clk_filt) begin
        run_len <= '0;
      end else if (run_len == FW'(FILTER_LEN - 1)) begin
        clk_filt <= clk_meta[1];
        fall_evt <= clk_filt;
        run_len  <= '0;
      end else begin
        run_len <= run_len + FW'(1);
      end
    end
  end

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter with open-drain line
// enables, ACK check and clock-release timeout.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ     = 100_000_000,
  parameter int unsigned INHIBIT_US      = 100,
  parameter int unsigned START_SETUP_CYC = 200,
  parameter int unsigned TIMEOUT_US      = 15000,
  parameter int unsigned FILTER_LEN      = 4
) (
  input  logic         clk,
  input  logic         rst,
  ps2_host_tx_if.slave tx,
  input  logic         ps2_clk_in,
  input  logic         ps2_data_in,
  output logic         ps2_clk_oe,
  output logic         ps2_data_oe
);

  localparam int unsigned INH_CYC =
    us_to_cyc(CLK_FREQ_HZ, INHIBIT_US);
  localparam int unsigned TO_CYC =
    us_to_cyc(CLK_FREQ_HZ, TIMEOUT_US);
  localparam int unsigned BIG =
    (INH_CYC > TO_CYC) ? INH_CYC : TO_CYC;
  localparam int unsigned CNT_MAX =
    (BIG > START_SETUP_CYC) ? BIG : START_SETUP_CYC;
  localparam int unsigned CW =
    (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

  localparam logic [CW-1:0] INH_LAST = CW'(INH_CYC - 1);
  localparam logic [CW-1:0] SET_LAST = CW'(START_SETUP_CYC - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(TO_CYC - 1);

  ps2_tx_state_e state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [3:0]    bit_idx, bit_idx_d;
  logic [7:0]    data_q, data_d;
  logic          par_q, par_d;
  logic          data_low, data_low_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          alive;
  logic          ready_w;
  logic          frame_bit;

  logic clk_filt;
  logic data_sync;
  logic fall_evt;

  ps2_line_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_filt (
    .clk      (clk),
    .rst      (rst),
    .clk_in   (ps2_clk_in),
    .data_in  (ps2_data_in),
    .clk_filt (clk_filt),
    .data_sync(data_sync),
    .fall_evt (fall_evt)
  );

  assign ready_w     = alive && (state == ST_IDLE);
  assign tx.tx_ready = ready_w;
  assign tx.busy     = (state != ST_IDLE);
  assign tx.tx_done  = done_q;
  assign tx.tx_err   = err_q;

  // Select the frame bit for the current index: data, parity, stop.
  always_comb begin
    frame_bit = 1'b1;
    unique case (1'b1)
      (bit_idx < 4'd8):  frame_bit = data_q[bit_idx[2:0]];
      (bit_idx == 4'd8): frame_bit = par_q;
      default:           frame_bit = 1'b1;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Datapath registers; ready comes up one edge after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt      <= '0;
      bit_idx  <= '0;
      data_q   <= '0;
      par_q    <= 1'b0;
      data_low <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      alive    <= 1'b0;
    end else begin
      cnt      <= cnt_d;
      bit_idx  <= bit_idx_d;
      data_q   <= data_d;
      par_q    <= par_d;
      data_low <= data_low_d;
      done_q   <= done_d;
      err_q    <= err_d;
      alive    <= 1'b1;
    end
  end

  // Next state, counters and line enables.
  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    bit_idx_d   = bit_idx;
    data_d      = data_q;
    par_d       = par_q;
    data_low_d  = data_low;
    done_d      = 1'b0;
    err_d       = err_q;
    ps2_clk_oe  = 1'b0;
    ps2_data_oe = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (tx.tx_valid && ready_w) begin
          data_d  = tx.tx_data;
          par_d   = ~^tx.tx_data;
          err_d   = 1'b0;
          cnt_d   = '0;
          state_d = ST_INHIBIT;
        end
      end
      ST_INHIBIT: begin
        ps2_clk_oe = 1'b1;
        if (cnt == INH_LAST) begin
          cnt_d   = '0;
          state_d = ST_START;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      ST_START: begin
        ps2_clk_oe  = 1'b1;
        ps2_data_oe = 1'b1;
        if (cnt == SET_LAST) begin
          cnt_d      = '0;
          bit_idx_d  = '0;
          data_low_d = 1'b1;
          state_d    = ST_SHIFT;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      ST_SHIFT: begin
        ps2_data_oe = data_low;
        if (cnt == TO_LAST) begin
          data_low_d = 1'b0;
          done_d     = 1'b1;
          err_d      = 1'b1;
          state_d    = ST_IDLE;
        end else begin
          cnt_d = cnt + CW'(1);
          if (fall_evt) begin
            data_low_d = ~frame_bit;
            bit_idx_d  = bit_idx + 4'd1;
            if (bit_idx == 4'd9) begin
              state_d = ST_ACK;
            end
          end
        end
      end
      ST_ACK: begin
        if (cnt == TO_LAST) begin
          done_d  = 1'b1;
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt + CW'(1);
          if (fall_evt) begin
            err_d   = data_sync;
            state_d = ST_WAIT_IDLE;
          end
        end
      end
      ST_WAIT_IDLE: begin
        if (clk_filt && data_sync) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Scoreboard bench for ps2_host_tx with a behavioural PS/2
// device model driving the shared open-drain lines.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int unsigned CLK_HZ = 100_000_000;
  localparam int unsigned INH_US = 10;
  localparam int unsigned SETUP  = 200;
  localparam int unsigned TO_US  = 50;
  localparam int unsigned INH_CYC = INH_US * 100;
  localparam int unsigned TO_CYC  = TO_US * 100;
  localparam int H = 60;
  localparam int M_ACK = 0;
  localparam int M_NACK = 1;
  localparam int M_SILENT = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ps2_host_tx_if bus();

  logic ps2_clk_oe;
  logic ps2_data_oe;
  logic dev_clk_low = 1'b0;
  logic dev_data_low = 1'b0;
  logic glitch = 1'b0;
  logic pad_clk;
  logic pad_data;
  assign pad_clk  = ~(ps2_clk_oe | dev_clk_low | glitch);
  assign pad_data = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx #(
    .CLK_FREQ_HZ    (CLK_HZ),
    .INHIBIT_US     (INH_US),
    .START_SETUP_CYC(SETUP),
    .TIMEOUT_US     (TO_US),
    .FILTER_LEN     (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tx         (bus),
    .ps2_clk_in (pad_clk),
    .ps2_data_in(pad_data),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe)
  );

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int rel_cyc = 0;
  int dev_mode = M_ACK;
  int dev_falls = 0;
  bit dev_active = 1'b0;
  bit abort = 1'b0;
  logic [9:0] exp_frame_q[$];
  logic       exp_err_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [9:0] frame_of(input logic [7:0] d);
    logic par;
    par = ($countones(d) % 2) == 0;
    return {1'b1, par, d};
  endfunction

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic run_frame();
    logic [9:0] got;
    bit cut;
    got = '0;
    cut = 1'b0;
    dev_active = 1'b1;
    dev_falls = 0;
    hold(H);
    for (int i = 0; i < 11 && !cut; i++) begin
      dev_clk_low = 1'b1;
      dev_falls = i + 1;
      hold(H);
      dev_clk_low = 1'b0;
      if (abort) begin
        cut = 1'b1;
      end else begin
        if (i < 10) got[i] = pad_data;
        if (i == 9 && dev_mode == M_ACK) dev_data_low = 1'b1;
        hold(H);
        if (i == 10) dev_data_low = 1'b0;
        if (abort) cut = 1'b1;
      end
    end
    dev_clk_low = 1'b0;
    dev_data_low = 1'b0;
    if (!cut) begin
      if (exp_frame_q.size() == 0)
        check("unexpected_frame", 1, 0);
      else
        check("frame_bits", got, exp_frame_q.pop_front());
    end
    dev_active = 1'b0;
  endtask

  initial begin : device
    bit armed;
    armed = 1'b0;
    forever begin
      @(negedge clk);
      if (ps2_clk_oe) begin
        armed = 1'b1;
      end else if (armed) begin
        armed = 1'b0;
        if (ps2_data_oe && dev_mode != M_SILENT && !abort)
          run_frame();
      end
    end
  end

  initial begin : done_mon
    forever begin
      @(negedge clk);
      if (bus.tx_done) begin
        done_cnt++;
        done_cyc = cyc;
        check("done_lines", {ps2_clk_oe, ps2_data_oe}, 0);
        check("done_busy", bus.busy, 0);
        if (exp_err_q.size() == 0)
          check("unexpected_done", 1, 0);
        else
          check("tx_err", bus.tx_err, exp_err_q.pop_front());
      end
      if (bus.busy) check("ready_while_busy", bus.tx_ready, 0);
    end
  end

  initial begin : oe_watch
    logic prev_c;
    bit seen_d;
    int rise;
    prev_c = 1'b0;
    seen_d = 1'b0;
    rise = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev_c = 1'b0;
        seen_d = 1'b0;
      end else begin
        if (ps2_clk_oe && !prev_c) begin
          rise = cyc;
          seen_d = 1'b0;
        end
        if (ps2_clk_oe && ps2_data_oe && !seen_d) begin
          seen_d = 1'b1;
          check("inhibit_len", cyc - rise, INH_CYC);
        end
        if (!ps2_clk_oe && prev_c) begin
          rel_cyc = cyc;
          check("clk_hold_len", cyc - rise, INH_CYC + SETUP);
        end
        prev_c = ps2_clk_oe;
      end
    end
  end

  task automatic send(input logic [7:0] d);
    int t;
    t = 0;
    while (!bus.tx_ready && t < 20000) begin
      @(negedge clk);
      t++;
    end
    check("ready_wait", bus.tx_ready, 1);
    bus.tx_data = d;
    bus.tx_valid = 1'b1;
    @(negedge clk);
    bus.tx_valid = 1'b0;
  endtask

  task automatic xfer(input logic [7:0] d, input int mode);
    dev_mode = mode;
    if (mode != M_SILENT) exp_frame_q.push_back(frame_of(d));
    exp_err_q.push_back(mode != M_ACK);
    send(d);
  endtask

  task automatic wait_done(input int n0);
    int t;
    t = 0;
    while (done_cnt <= n0 && t < 20000) begin
      @(negedge clk);
      t++;
    end
    check("done_seen", done_cnt > n0, 1);
    @(negedge clk);
    check("busy_after_done", bus.busy, 0);
  endtask

  task automatic wait_falls(input int n);
    int t;
    t = 0;
    while (dev_falls < n && t < 5000) begin
      @(negedge clk);
      t++;
    end
    check("falls_seen", dev_falls >= n, 1);
  endtask

  initial begin : main
    int n0;
    int t;
    logic [7:0] d;
    int mode;
    bus.tx_data = 8'h00;
    bus.tx_valid = 1'b0;
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", bus.tx_ready, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.tx_done, 0);
    check("rst_err", bus.tx_err, 0);
    check("rst_clk_oe", ps2_clk_oe, 0);
    check("rst_data_oe", ps2_data_oe, 0);
    rst = 1'b1;
    #1 check("ready_pre_edge", bus.tx_ready, 0);
    @(posedge clk);
    #1 check("ready_post_edge", bus.tx_ready, 1);
    @(negedge clk);

    n0 = done_cnt;
    xfer(CMD_ENABLE, M_ACK);
    wait_done(n0);

    n0 = done_cnt;
    xfer(CMD_RESET, M_ACK);
    wait_done(n0);

    n0 = done_cnt;
    xfer(CMD_SET_RATE, M_NACK);
    wait_done(n0);

    n0 = done_cnt;
    xfer(8'hA5, M_SILENT);
    wait_done(n0);
    check("timeout_latency", done_cyc - rel_cyc, TO_CYC);
    dev_mode = M_ACK;

    dev_falls = 0;
    send(8'hE8);
    wait_falls(5);
    hold(20);
    check("pre_rst_data_oe", ps2_data_oe, 1);
    abort = 1'b1;
    #1 rst = 1'b0;
    #1 check("rst_mid_lines", {ps2_clk_oe, ps2_data_oe}, 0);
    t = 0;
    while (dev_active && t < 1000) begin
      @(negedge clk);
      t++;
    end
    check("dev_aborted", dev_active, 0);
    abort = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1 check("ready_pre_edge2", bus.tx_ready, 0);
    @(posedge clk);
    #1 check("ready_post_edge2", bus.tx_ready, 1);
    @(negedge clk);
    n0 = done_cnt;
    xfer(CMD_ENABLE, M_ACK);
    wait_done(n0);

    dev_falls = 0;
    n0 = done_cnt;
    xfer(CMD_ENABLE, M_ACK);
    wait_falls(3);
    t = 0;
    while (dev_clk_low && t < 1000) begin
      @(negedge clk);
      t++;
    end
    hold(20);
    glitch = 1'b1;
    hold(2);
    glitch = 1'b0;
    bus.tx_data = 8'h00;
    bus.tx_valid = 1'b1;
    hold(3);
    bus.tx_valid = 1'b0;
    wait_done(n0);
    hold(2000);
    check("single_done", done_cnt, n0 + 1);
    check("no_second_xfer", bus.busy, 0);

    for (int k = 0; k < 6; k++) begin
      d = 8'($urandom);
      mode = int'($urandom_range(0, 1));
      n0 = done_cnt;
      xfer(d, mode);
      wait_done(n0);
    end

    hold(100);
    check("pending_done", exp_err_q.size(), 0);
    check("pending_frame", exp_frame_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
